// File: rtl/request_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : request_unit_pkg
// Description : Shared types for the multi-channel request unit: per-channel
//               state encoding and latched request type.
// Revision    : 1.0 - initial release
// ============================================================================
package request_unit_pkg;

  typedef enum logic [1:0] {
    RU_IDLE   = 2'd0,
    RU_DPEND  = 2'd1,
    RU_HALTED = 2'd2
  } ru_state_t;

  typedef enum logic {
    RU_READ  = 1'b0,
    RU_WRITE = 1'b1
  } ru_type_t;

endpackage : request_unit_pkg
`default_nettype wire

// File: rtl/request_unit_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : request_unit_mc_if
// Description : Signal bundle between NCH datapaths, the request unit and
//               the memory/cache control.
//               Modport ru : view of the request unit itself.
//               Modport tb : view of whatever drives the request unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface request_unit_mc_if #(
  parameter int NCH = 2
) (
  input logic CLK
);

  logic           RST;
  logic [NCH-1:0] halt;
  logic [NCH-1:0] iREN;
  logic [NCH-1:0] dREN;
  logic [NCH-1:0] dWEN;
  logic [NCH-1:0] ihit;
  logic [NCH-1:0] dhit;
  logic [NCH-1:0] imemREN;
  logic [NCH-1:0] dmemREN;
  logic [NCH-1:0] dmemWEN;
  logic [NCH-1:0] dgrant;
  logic           dbusy;
  logic [NCH-1:0] timeout;

  modport ru (
    input  CLK, RST, halt, iREN, dREN, dWEN, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, dgrant, dbusy, timeout
  );

  modport tb (
    input  CLK, imemREN, dmemREN, dmemWEN, dgrant, dbusy, timeout,
    output RST, halt, iREN, dREN, dWEN, ihit, dhit
  );

endinterface : request_unit_mc_if
`default_nettype wire

// File: rtl/request_unit_mc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Grants the first
//               requester at or after ptr, wrapping modulo N.
//   req   in  N      request vector
//   ptr   in  PTR_W  highest-priority index
//   gnt   out N      one-hot grant, or 0 when no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic w_found;

  // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && req[j] && (j >= int'(ptr))) begin
        gnt[j]  = 1'b1;
        w_found = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && req[j]) begin
        gnt[j]  = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/request_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : request_unit_mc
// Description : Multi-channel request unit. Each channel holds a data read or
//               write request from its issuing ihit until the matching dhit
//               and gates instruction fetch after halt. All channels share one
//               data port through a registered round-robin grant.
// Optional    : REQ_TIMEOUT_EN - per-channel granted-request timeout counters.
//               Without it, timeout is tied to 0.
// Ports       : CLK, RST (sync, active-high)
//               halt/iREN/dREN/dWEN/ihit/dhit  in  [NCH] per-channel controls
//               imemREN                        out [NCH] fetch request
//               dmemREN/dmemWEN                out [NCH] granted data request
//               dgrant                         out [NCH] one-hot grant or 0
//               dbusy                          out       OR of dgrant
//               timeout                        out [NCH] granted request stalled
// Revision    : 1.0 - initial release
// ============================================================================
module request_unit_mc
  import request_unit_pkg::*;
#(
  parameter int NCH            = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] halt,
  input  logic [NCH-1:0] iREN,
  input  logic [NCH-1:0] dREN,
  input  logic [NCH-1:0] dWEN,
  input  logic [NCH-1:0] ihit,
  input  logic [NCH-1:0] dhit,
  output logic [NCH-1:0] imemREN,
  output logic [NCH-1:0] dmemREN,
  output logic [NCH-1:0] dmemWEN,
  output logic [NCH-1:0] dgrant,
  output logic           dbusy,
  output logic [NCH-1:0] timeout
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  ru_state_t        r_state    [NCH];
  ru_state_t        w_state_nxt[NCH];
  ru_type_t         r_type     [NCH];
  ru_type_t         w_type_nxt [NCH];

  logic [NCH-1:0]   r_dgrant;
  logic [PTR_W-1:0] r_ptr;
  logic [NCH-1:0]   w_gnt;
  logic [NCH-1:0]   w_grant_load;
  logic [NCH-1:0]   w_pend;
  logic [NCH-1:0]   w_new_req;
  logic [NCH-1:0]   w_halt_hit;
  logic [NCH-1:0]   w_release_vec;
  logic             w_release;
  logic [NCH-1:0]   w_is_read;
  logic [NCH-1:0]   w_is_write;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_ptr_nxt;

  assign w_new_req     = ihit & (dREN | dWEN);
  assign w_halt_hit    = ihit & halt;
  assign w_release_vec = r_dgrant & dhit;  // dhit on a non-granted channel is ignored
  assign w_release     = |w_release_vec;
  assign w_grant_load  = (r_dgrant == '0) ? w_gnt : '0;

  // --------------------------------------------------------------------------
  // Per-channel FSM
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_type_nxt[i]  = r_type[i];
      w_pend[i]      = (r_state[i] == RU_DPEND);
      w_is_read[i]   = (r_type[i] == RU_READ);
      w_is_write[i]  = (r_type[i] == RU_WRITE);
      imemREN[i]     = iREN[i] & (r_state[i] != RU_HALTED) & ~RST;
      case (r_state[i])
        RU_IDLE: begin
          if (w_halt_hit[i]) begin
            w_state_nxt[i] = RU_HALTED;
          end else if (w_new_req[i]) begin
            w_state_nxt[i] = RU_DPEND;
            w_type_nxt[i]  = dWEN[i] ? RU_WRITE : RU_READ;
          end
        end
        RU_DPEND: begin
          // A new request or halt is only taken together with the releasing
          // dhit; until then the pending type is held untouched.
          if (w_release_vec[i]) begin
            if (w_halt_hit[i]) begin
              w_state_nxt[i] = RU_HALTED;
            end else if (w_new_req[i]) begin
              w_state_nxt[i] = RU_DPEND;
              w_type_nxt[i]  = dWEN[i] ? RU_WRITE : RU_READ;
            end else begin
              w_state_nxt[i] = RU_IDLE;
            end
          end
        end
        RU_HALTED: w_state_nxt[i] = RU_HALTED;
        default:   w_state_nxt[i] = RU_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (RST) begin
        r_state[i] <= RU_IDLE;
        r_type[i]  <= RU_READ;
      end else begin
        r_state[i] <= w_state_nxt[i];
        r_type[i]  <= w_type_nxt[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shared-port arbitration
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .N     (NCH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (w_pend),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_dgrant[i]) begin
        w_gidx = PTR_W'(i);
      end
    end
    w_ptr_nxt = (w_gidx == PTR_W'(NCH - 1)) ? '0 : (w_gidx + 1'b1);
  end

  // A grant is only loaded while the port is free, so the release edge always
  // leaves one grant-free cycle before the next owner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dgrant <= '0;
      r_ptr    <= '0;
    end else if (r_dgrant != '0) begin
      if (w_release) begin
        r_dgrant <= '0;
        r_ptr    <= w_ptr_nxt;
      end
    end else begin
      r_dgrant <= w_gnt;
    end
  end

  assign dgrant  = r_dgrant;
  assign dbusy   = |r_dgrant;
  assign dmemREN = r_dgrant & w_is_read;
  assign dmemWEN = r_dgrant & w_is_write;

  // --------------------------------------------------------------------------
  // Granted-request timeout
  // --------------------------------------------------------------------------
`ifdef REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt [NCH];
  logic [NCH-1:0]   r_timeout;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (RST) begin
        r_cnt[i]     <= '0;
        r_timeout[i] <= 1'b0;
      end else begin
        if (w_grant_load[i]) begin
          r_cnt[i] <= '0;
        end else if (r_dgrant[i] && (r_cnt[i] != CNT_W'(TIMEOUT_CYCLES))) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        // Flag rises on the same edge the count lands on the limit.
        if (w_release_vec[i]) begin
          r_timeout[i] <= 1'b0;
        end else if (r_dgrant[i] && (r_cnt[i] == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          r_timeout[i] <= 1'b1;
        end
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = '0;
`endif

endmodule : request_unit_mc
`default_nettype wire

// File: doc/request_unit_mc.md
Name: request_unit_mc

Overview:
- Multi-channel successor to the single-channel request unit, with a generalised channel count.
- Each channel is one datapath: it holds a data-memory read or write request from the ihit that issues it until the matching dhit, and gates instruction fetch after halt.
- All channels share one data-memory port through a registered round-robin grant.
- Sits between NCH datapaths and the memory/cache control.

Parameters:
- NCH, 2, number of datapath channels (≥1)
- TIMEOUT_CYCLES, 255, granted-request cycle limit (used only with REQ_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous reset, active-high
- halt  in  NCH  per-channel halt from datapath
- iREN  in  NCH  instruction read enable
- dREN  in  NCH  data read enable
- dWEN  in  NCH  data write enable
- ihit  in  NCH  instruction fetch complete
- dhit  in  NCH  data access complete
- imemREN  out  NCH  instruction memory read request
- dmemREN  out  NCH  data read request (only on the granted channel)
- dmemWEN  out  NCH  data write request (only on the granted channel)
- dgrant  out  NCH  one-hot shared data-port grant, or 0
- dbusy  out  1  OR of dgrant
- timeout  out  NCH  granted request exceeded limit (see Optional Feature)

Behaviour:
- One clock, CLK; reset RST is synchronous and active-high. All state updates on the rising edge of CLK.
- Reset values:
  - dmemREN=0, dmemWEN=0, dgrant=0, dbusy=0, timeout=0.
  - imemREN forced 0 while RST=1.
  - All channels go to RU_IDLE; type registers cleared; round-robin pointer=0.
- Per-channel FSM, RU_IDLE / RU_DPEND / RU_HALTED:
  - RU_IDLE:
    - ihit&halt → RU_HALTED.
    - Else ihit&(dREN|dWEN) → RU_DPEND, latching type as write if dWEN, else read. dWEN wins if both are high.
    - Else stay.
  - RU_DPEND:
    - dhit&dgrant[i] → RU_IDLE.
    - If ihit&(dREN|dWEN) in that same cycle, re-latch and stay in RU_DPEND (back-to-back request; the grant still releases).
    - If ihit&halt in that same cycle → RU_HALTED.
    - dhit on a non-granted channel is ignored.
  - RU_HALTED: sticky until RST. imemREN=0, no data requests.
- imemREN[i] = iREN[i] & (state≠RU_HALTED) & ~RST. This is combinational.
- Arbitration (registered):
  - When dgrant=0 and any channel is RU_DPEND, the next edge grants the first pending channel at or after the pointer, modulo NCH.
  - The grant is held while that channel stays in RU_DPEND.
  - On the releasing dhit edge: dgrant→0 and pointer←(granted index+1) mod NCH.
  - There is always at least one grant-free cycle between consecutive grants.
- dmemREN[i] = dgrant[i] & type_is_read[i]; dmemWEN[i] = dgrant[i] & type_is_write[i]. Never both on the same channel.
- Latency:
  - ihit edge E0 → pending after E0.
  - Grant after E1 (if the port is free).
  - dmem* asserted from E1 until the dhit edge.
- Simultaneous requests: exactly one grant; the others wait, with their request type held unchanged.
- RST asserted mid-request: the request is dropped and all outputs return to their reset values on the next edge.

Optional Feature:
- Macro REQ_TIMEOUT_EN.
- Defined:
  - Per-channel counter, width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on grant; increments each cycle while dgrant[i]; saturates.
  - timeout[i] set when count reaches TIMEOUT_CYCLES.
  - timeout[i] is sticky until the releasing dhit or RST.
- Not defined: timeout tied to 0, no counters synthesised. The port is always present.

Decomposition:
- Shared package (cpu_types_pkg or a new request_unit_pkg) holds:
  - typedef enum logic [1:0] ru_state_t {RU_IDLE, RU_DPEND, RU_HALTED};
  - typedef enum logic ru_type_t {RU_READ, RU_WRITE}.
- Interface request_unit_mc_if is parametrised by NCH, with modports ru and tb.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N], ptr; output gnt one-hot.
  - Purely combinational; the top level registers its result.

Test Plan (NCH=2 unless noted):
- Reset/fetch:
  - RST=1 with iREN=2'b11 → imemREN=0, dgrant=0.
  - After RST=0 → imemREN=2'b11.
- Single read: ch0 ihit=1, dREN=1 for one cycle →
  - dgrant=2'b01 and dmemREN=2'b01 after two edges, held until dhit[0].
  - Next cycle dgrant=0 and pointer=1.
- Contention: both channels issue at the same edge (ch0 write, ch1 read) with pointer=0 →
  - ch0 granted first with dmemWEN=2'b01.
  - After dhit, one idle cycle, then ch1 gets dmemREN=2'b10.
  - Pointer ends at 0.
- Back-to-back: ch0 dhit and ihit+dREN in the same cycle → stays RU_DPEND, grant released, re-granted after one idle cycle.
- Halt: ch1 ihit with halt=1 → imemREN[1]=0 permanently; later dREN[1] is ignored; cleared only by RST.
- REQ_TIMEOUT_EN with TIMEOUT_CYCLES=4, granted ch0 and no dhit → timeout[0]=1 after 4 granted cycles; cleared at dhit. Without the macro, timeout stays 0.
